// File: rtl/cpu_param_if.sv
// Data-memory bus between cpu_param and a variable-latency memory.
// The CPU holds its request while BUSYWAIT is high.
interface cpu_param_if #(
  parameter int unsigned DATA_W = 8
);
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [DATA_W-1:0] MEM_ADDRESS;
  logic [DATA_W-1:0] MEM_WRITEDATA;
  logic [DATA_W-1:0] MEM_READDATA;
  logic              BUSYWAIT;

  modport master (
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    input  MEM_READDATA, BUSYWAIT
  );

  modport slave (
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    output MEM_READDATA, BUSYWAIT
  );
endinterface

// File: rtl/cpu_param.sv
// Parametrised single-issue CPU: ALU ops, j/beq/bne, and load/store that
// stall in MEM_WAIT until the data memory drops BUSYWAIT.
module cpu_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned REG_ADDR_W = 3,
  parameter logic [31:0] PC_RESET   = 32'h0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  output logic [31:0] PC,
  cpu_param_if.master mem
);
  localparam int unsigned NREGS = 2 ** REG_ADDR_W;
  localparam int unsigned IMM_W = (DATA_W < 8) ? DATA_W : 8;

  typedef enum logic {EXEC, MEM_WAIT} state_t;
  state_t state, state_next;

  logic [DATA_W-1:0]     regs [NREGS];
  logic [7:0]            opcode;
  logic [REG_ADDR_W-1:0] rd, rt, rs;
  logic [DATA_W-1:0]     rt_val, rs_val, imm, alu, wdata;
  logic [31:0]           offset, pc_seq, pc_next;
  logic                  reg_we, is_load, is_store, taken;
  logic                  unused_fields;

  assign opcode = INSTRUCTION[31:24];
  assign rd     = INSTRUCTION[16 +: REG_ADDR_W];
  assign rt     = INSTRUCTION[8 +: REG_ADDR_W];
  assign rs     = INSTRUCTION[0 +: REG_ADDR_W];
  assign rt_val = regs[rt];
  assign rs_val = regs[rs];
  assign imm    = DATA_W'(INSTRUCTION[IMM_W-1:0]);
  assign offset = {{22{INSTRUCTION[23]}}, INSTRUCTION[23:16], 2'b00};
  assign pc_seq = PC + 32'd4;
  assign unused_fields = ^INSTRUCTION[15:8];

  assign is_load  = (opcode == 8'h09) || (opcode == 8'h0A);
  assign is_store = (opcode == 8'h0B) || (opcode == 8'h0C);
  assign taken    = (opcode == 8'h06)
                 || ((opcode == 8'h07) && (rt_val == rs_val))
                 || ((opcode == 8'h08) && (rt_val != rs_val));

  always_comb begin
    alu = '0;
    case (opcode)
      8'h00:   alu = imm;
      8'h01:   alu = rs_val;
      8'h02:   alu = rt_val + rs_val;
      8'h03:   alu = rt_val - rs_val;
      8'h04:   alu = rt_val & rs_val;
      8'h05:   alu = rt_val | rs_val;
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    pc_next    = PC;
    reg_we     = 1'b0;
    wdata      = alu;
    case (state)
      EXEC: begin
        if (is_load || is_store) begin
          state_next = MEM_WAIT;
        end else begin
          pc_next = taken ? pc_seq + offset : pc_seq;
          reg_we  = (opcode <= 8'h05);
        end
      end
      MEM_WAIT: begin
        if (!mem.BUSYWAIT) begin
          state_next = EXEC;
          pc_next    = pc_seq;
          reg_we     = is_load;
          wdata      = mem.MEM_READDATA;
        end
      end
      default: state_next = EXEC;
    endcase
  end

  // Requests are decoded straight from the instruction in both states; reset masks them.
  assign mem.MEM_READ      = !RESET && is_load;
  assign mem.MEM_WRITE     = !RESET && is_store;
  assign mem.MEM_ADDRESS   = ((opcode == 8'h09) || (opcode == 8'h0B)) ? rs_val : imm;
  assign mem.MEM_WRITEDATA = rt_val;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= EXEC;
      PC    <= PC_RESET;
      regs  <= '{default: '0};
    end else begin
      state <= state_next;
      PC    <= pc_next;
      if (reg_we) regs[rd] <= wdata;
    end
  end
endmodule

// File: tb/tb_cpu_param.sv
// Bench for cpu_param: instruction-level reference model checked every cycle,
// plus literal expectations for the directed program and a 16-bit build.
module tb_cpu_param;
  localparam logic [31:0] NOP = 32'h0D0102FF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = NOP;
  logic [31:0] instr16 = NOP;
  logic        busy = 1'b0;
  logic [7:0]  rdata = 8'h00;
  logic [31:0] pc8, pc16;
  bit          chk_en = 1'b0;
  int          total = 0;
  int          passed = 0;

  cpu_param_if #(.DATA_W(8))  bus8();
  cpu_param_if #(.DATA_W(16)) bus16();

  assign bus8.BUSYWAIT      = busy;
  assign bus8.MEM_READDATA  = rdata;
  assign bus16.BUSYWAIT     = 1'b0;
  assign bus16.MEM_READDATA = 16'h0000;

  cpu_param #(.DATA_W(8), .REG_ADDR_W(3), .PC_RESET(32'h0)) dut (
    .CLK(clk), .RESET(rst), .INSTRUCTION(instr), .PC(pc8), .mem(bus8)
  );

  cpu_param #(.DATA_W(16), .REG_ADDR_W(4), .PC_RESET(32'h0)) dut16 (
    .CLK(clk), .RESET(rst), .INSTRUCTION(instr16), .PC(pc16), .mem(bus16)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Instruction-level model: a memory op spends one edge issuing, then completes
  // at the first later edge with busy low.
  logic [7:0]  m_regs [8];
  logic [31:0] m_pc;
  bit          m_pending;

  always @(posedge clk or posedge rst) begin : model
    logic [7:0]  op, a, b;
    logic [31:0] off;
    bit          br;
    if (rst) begin
      m_pc = 32'h0;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_pending = 1'b0;
    end else begin
      op  = instr[31:24];
      a   = m_regs[instr[10:8]];
      b   = m_regs[instr[2:0]];
      off = 32'($signed(instr[23:16])) * 4;
      if (op >= 8'h09 && op <= 8'h0C) begin
        if (!m_pending) m_pending = 1'b1;
        else if (!busy) begin
          if (op == 8'h09 || op == 8'h0A) m_regs[instr[18:16]] = rdata;
          m_pc = m_pc + 4;
          m_pending = 1'b0;
        end
      end else begin
        case (op)
          8'h00: m_regs[instr[18:16]] = instr[7:0];
          8'h01: m_regs[instr[18:16]] = b;
          8'h02: m_regs[instr[18:16]] = a + b;
          8'h03: m_regs[instr[18:16]] = a - b;
          8'h04: m_regs[instr[18:16]] = a & b;
          8'h05: m_regs[instr[18:16]] = a | b;
          default: ;
        endcase
        br = (op == 8'h06) || (op == 8'h07 && a == b) || (op == 8'h08 && a != b);
        m_pc = m_pc + 4 + (br ? off : 32'h0);
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [7:0] op;
    bit e_rd, e_wr;
    if (chk_en) begin
      op   = instr[31:24];
      e_rd = !rst && (op == 8'h09 || op == 8'h0A);
      e_wr = !rst && (op == 8'h0B || op == 8'h0C);
      check("pc", pc8, m_pc);
      check("mem_read", 32'(bus8.MEM_READ), 32'(e_rd));
      check("mem_write", 32'(bus8.MEM_WRITE), 32'(e_wr));
      if (e_rd || e_wr)
        check("mem_address", 32'(bus8.MEM_ADDRESS),
              (op == 8'h09 || op == 8'h0B) ? 32'(m_regs[instr[2:0]]) : 32'(instr[7:0]));
      if (e_wr) check("mem_writedata", 32'(bus8.MEM_WRITEDATA), 32'(m_regs[instr[10:8]]));
      for (int i = 0; i < 8; i++) check($sformatf("reg r%0d", i), 32'(dut.regs[i]), 32'(m_regs[i]));
    end
  end

  task automatic drive(input logic [31:0] ins, input logic bw);
    instr = ins;
    busy  = bw;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive16(input logic [31:0] ins);
    instr16 = ins;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 chk_en = 1'b1;
    check("reset pc", pc8, 32'h0);
    check("reset mem_read", 32'(bus8.MEM_READ), 32'h0);
    for (int i = 0; i < 8; i++) check($sformatf("reset r%0d", i), 32'(dut.regs[i]), 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;

    drive(32'h00010005, 1'b0);
    drive(32'h00020003, 1'b0);
    check("loadi r1", 32'(dut.regs[1]), 32'h05);
    check("loadi r2", 32'(dut.regs[2]), 32'h03);
    check("pc after loadi", pc8, 32'h8);

    drive(32'h02030102, 1'b0);
    check("add r3", 32'(dut.regs[3]), 32'h08);
    drive(32'h03040201, 1'b0);
    check("sub r4", 32'(dut.regs[4]), 32'hFE);
    drive(32'h000600F0, 1'b0);
    drive(32'h0007003C, 1'b0);
    drive(32'h05000607, 1'b0);
    drive(32'h04060607, 1'b0);
    check("or r0", 32'(dut.regs[0]), 32'hFC);
    check("and r6", 32'(dut.regs[6]), 32'h30);
    check("pc before branches", pc8, 32'h20);

    drive(32'h07FE0101, 1'b0);
    check("beq taken back", pc8, 32'h1C);
    drive(32'h08050101, 1'b0);
    check("bne not taken", pc8, 32'h20);
    drive(32'h06020000, 1'b0);
    check("j fwd", pc8, 32'h2C);
    drive(32'h08010102, 1'b0);
    check("bne taken", pc8, 32'h34);
    drive(32'h07030102, 1'b0);
    check("beq not taken", pc8, 32'h38);

    rdata = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      drive(32'h0A050020, 1'b1);
      check("lwi stall pc", pc8, 32'h38);
      check("lwi stall read", 32'(bus8.MEM_READ), 32'h1);
      check("lwi stall write", 32'(bus8.MEM_WRITE), 32'h0);
      check("lwi stall addr", 32'(bus8.MEM_ADDRESS), 32'h20);
    end
    drive(32'h0A050020, 1'b0);
    check("lwi r5", 32'(dut.regs[5]), 32'hA5);
    check("lwi pc", pc8, 32'h3C);

    drive(32'h00070040, 1'b0);
    rdata = 8'h5A;
    drive(32'h09040001, 1'b0);
    drive(32'h09040001, 1'b0);
    check("lwd min latency r4", 32'(dut.regs[4]), 32'h5A);
    check("lwd pc", pc8, 32'h44);

    for (int i = 0; i < 3; i++) drive(32'h0B000107, 1'b1);
    check("swd write", 32'(bus8.MEM_WRITE), 32'h1);
    check("swd addr", 32'(bus8.MEM_ADDRESS), 32'h40);
    check("swd data", 32'(bus8.MEM_WRITEDATA), 32'h05);
    check("swd pc held", pc8, 32'h44);
    #1 rst = 1'b1;
    #1;
    check("reset mid-store write", 32'(bus8.MEM_WRITE), 32'h0);
    check("reset mid-store pc", pc8, 32'h0);
    check("reset mid-store r1", 32'(dut.regs[1]), 32'h0);
    instr = 32'h09020000;
    busy  = 1'b0;
    #1;
    check("read masked in reset", 32'(bus8.MEM_READ), 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;

    rdata = 8'h77;
    drive(32'h09020000, 1'b0);
    drive(32'h09020000, 1'b0);
    check("post-reset lwd r2", 32'(dut.regs[2]), 32'h77);
    check("post-reset pc", pc8, 32'h4);
    drive(NOP, 1'b0);
    check("nop pc", pc8, 32'h8);

    drive16(32'h000F00FF);
    drive16(32'h020E0F0F);
    check("w16 add r14", 32'(dut16.regs[14]), 32'h01FE);
    drive16(32'h00030007);
    drive16(32'h00010001);
    drive16(32'h03020001);
    check("w16 0-1", 32'(dut16.regs[2]), 32'hFFFF);
    drive16(32'h02030201);
    check("w16 wrap", 32'(dut16.regs[3]), 32'h0000);
    drive16(NOP);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cpu_param.md
# cpu_param

Parametrised single-issue CPU core, successor to the fixed 8-bit single-cycle core. Data width and register count are generic. It adds `bne`, load/store instructions and a data-memory request/`BUSYWAIT` handshake that stalls the PC. It sits between a combinational instruction memory (driven by `PC`) and a variable-latency data memory.

## Interface
- `DATA_W`, 8: register, ALU and data-memory word width; also the data address width.
- `REG_ADDR_W`, 3: register index width; register count is 2^REG_ADDR_W. Must be ≤ 8.
- `PC_RESET`, 32'h0: PC value loaded on reset.
- `CLK`  in  1: single clock; all state updates on its rising edge.
- `RESET`  in  1: asynchronous, active-high.
- `INSTRUCTION`  in  32: instruction at `PC`. Fields: OPCODE[31:24], RD/OFFSET[23:16], RT[15:8], RS/IMM[7:0].
- `PC`  out  32: current program counter.
- `MEM_READ`  out  1: data-memory read request.
- `MEM_WRITE`  out  1: data-memory write request.
- `MEM_ADDRESS`  out  DATA_W: data-memory address.
- `MEM_WRITEDATA`  out  DATA_W: store data.
- `MEM_READDATA`  in  DATA_W: load data, valid when `BUSYWAIT` is low in MEM_WAIT.
- `BUSYWAIT`  in  1: memory busy; the CPU holds its request while this is high.

## Operation
- Register indices use the low REG_ADDR_W bits of each field.
- IMM8 is zero-extended, or truncated, to DATA_W.
- OFFSET is sign-extended to 32 bits and shifted left by 2.
- Arithmetic is modulo 2^DATA_W.
- Opcodes:
  - 0x00 loadi: RD←IMM8
  - 0x01 mov: RD←RS
  - 0x02 add: RD←RT+RS
  - 0x03 sub: RD←RT−RS
  - 0x04 and: RD←RT&RS
  - 0x05 or: RD←RT|RS
  - 0x06 j
  - 0x07 beq: taken if RT==RS
  - 0x08 bne: taken if RT!=RS
  - 0x09 lwd: RD←MEM[RS]
  - 0x0A lwi: RD←MEM[IMM8]
  - 0x0B swd: MEM[RS]←RT
  - 0x0C swi: MEM[IMM8]←RT
  - Any other opcode is a NOP: PC+4, no register write, no memory request.
- Next PC:
  - j, and taken beq/bne: PC+4+OFFSET.
  - Otherwise: PC+4.
  - Wraps modulo 2^32.
- Register file: 2^REG_ADDR_W × DATA_W, two combinational read ports, one write port written at the rising edge.
- FSM, 2 states:
  - EXEC, the reset state:
    - Non-memory opcode: commits RD write and next PC at the edge, and stays in EXEC.
    - Memory opcode: asserts `MEM_READ` (lwd/lwi) or `MEM_WRITE` (swd/swi) combinationally, then moves to MEM_WAIT at the edge. PC holds and no register is written.
  - MEM_WAIT:
    - Request stays asserted, and address/write data stay driven from the (unchanged) instruction.
    - At an edge with `BUSYWAIT`=1: stay, with PC held.
    - At an edge with `BUSYWAIT`=0: for loads, RD←`MEM_READDATA`. PC←PC+4, go to EXEC. The request drops combinationally after that edge.
- `MEM_READ` and `MEM_WRITE` are never both 1.
- `MEM_ADDRESS` = RS value (lwd/swd) or IMM8 (lwi/swi).
- `MEM_WRITEDATA` = RT value.
- Both are don't-care when no request is active.
- Reset mid-operation (any state, including MEM_WAIT with `BUSYWAIT`=1):
  - Immediately: PC=PC_RESET, all registers=0, state=EXEC.
  - `MEM_READ`=`MEM_WRITE`=0 while `RESET` is high, and the pending load is discarded.
  - After release, the instruction at PC_RESET executes normally.

## Timing
- Reset values: `PC`=PC_RESET, registers 0, `MEM_READ`=0, `MEM_WRITE`=0.
- Non-memory instruction: 1 cycle. The result is visible on the read ports after the edge.
- Memory instruction: 2 + N cycles, where N is the number of MEM_WAIT edges with `BUSYWAIT`=1. The minimum is 2 cycles when `BUSYWAIT` is low at the first MEM_WAIT edge.
- `BUSYWAIT` is sampled only in MEM_WAIT; its value in EXEC is ignored.
- Memory must hold `MEM_READDATA` stable around the edge where `BUSYWAIT` is low.
- Write to r0 is legal; there is no hard-wired zero register.
- An instruction reading a register written by the previous instruction sees the new value, with no hazard logic.

## Test plan
- Reset with `RESET` pulsed high mid-cycle, asynchronous to `CLK` -> `PC`=0 immediately and all registers read 0. Then run loadi r1,5 (0x00010005) and loadi r2,3 (0x00020003) -> after 2 edges r1=5, r2=3, PC=8.
- Arithmetic, DATA_W=8:
  - add r3,r1,r2 (0x02030102) -> r3=8.
  - sub r4,r2,r1 (0x03040201) -> r4=0xFE.
  - or/and on 0xF0/0x3C -> 0xFC/0x30.
- Branching:
  - beq with equal operands, OFFSET=0xFE (0x07FE0101) at PC=0x10 -> PC=0x0C.
  - bne with equal operands at PC=0x10 -> PC=0x14.
  - j at PC=0x10 with OFFSET=0x02 -> PC=0x1C.
- Load with `BUSYWAIT`=1 for 3 MEM_WAIT edges:
  - lwi r5,0x20 with `MEM_READDATA`=0xA5 -> `MEM_READ`=1 and `MEM_ADDRESS`=0x20 for 5 cycles.
  - PC is constant throughout, then r5=0xA5 and PC+4 after the 5th edge.
  - `MEM_WRITE` stays 0 throughout.
- Store:
  - swd with r1=5 and RS reg=0x40 -> `MEM_WRITE`=1, `MEM_ADDRESS`=0x40, `MEM_WRITEDATA`=5 until `BUSYWAIT` falls.
  - No register changes.
  - `RESET` asserted during MEM_WAIT -> `MEM_WRITE` drops immediately and PC=0.
- Parametrised build (DATA_W=16, REG_ADDR_W=4):
  - loadi r15,0xFF, then add r14,r15,r15 -> r14=0x01FE.
  - 0xFFFF+1 wraps to 0.
